// File: rtl/demux_arr_module.sv
// demux_arr_module: registered valid/ready demultiplexer.
// Each accepted word is steered into a one-entry holding register on the lane
// selected by `in`. Every lane drains through its own out_valid/out_ready pair.
// An out-of-range lane index is swallowed, and it sets the sticky `err` flag.
// Optional feature: define DEMUX_ARR_BROADCAST_EN to add the `in_bcast` input.
// With it, one word can load every lane at once (all-or-nothing).
module demux_arr_module #(
   parameter int WIDTH_IN  = 2,
   parameter int WIDTH_OP  = 4,
   parameter int WIDTH_BUS = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH_IN-1:0]                 in,
   input  logic [WIDTH_BUS-1:0]                in_data,
`ifdef DEMUX_ARR_BROADCAST_EN
   input  logic                                in_bcast,
`endif
   output logic [WIDTH_OP-1:0][WIDTH_BUS-1:0]  out,
   output logic [WIDTH_OP-1:0]                 out_valid,
   input  logic [WIDTH_OP-1:0]                 out_ready,
   output logic                                err
);

   // The lane count is one bit wider than the index.
   // This lets WIDTH_OP == 2**WIDTH_IN be represented.
   localparam logic [WIDTH_IN:0] NUM_LANES = (WIDTH_IN+1)'(WIDTH_OP);

   logic [WIDTH_OP-1:0] lane_free;   // lane can take a word this cycle
   logic [WIDTH_OP-1:0] drain;       // lane's word is consumed this cycle
   logic [WIDTH_OP-1:0] load;        // lane captures in_data this cycle
   logic                in_range;
   logic                addr_free;
   logic                bcast;
   logic                accept;
   logic                oob;

   // A full lane that drains this cycle frees its slot in time to be reloaded.
   // This gives back-to-back throughput.
   assign lane_free = ~out_valid | out_ready;
   assign drain     = out_valid & out_ready;

`ifdef DEMUX_ARR_BROADCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // Decode the destination, form in_ready and pick the lane(s) to load.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch.
      // A path that leaves a signal unassigned would otherwise infer a latch.
      addr_free = 1'b0;
      load      = '0;
      in_range  = ({1'b0, in} < NUM_LANES);
      for (int k = 0; k < WIDTH_OP; k++) begin
         if (in == WIDTH_IN'(k)) addr_free = lane_free[k];
      end
      if (bcast)         in_ready = &lane_free;
      else if (in_range) in_ready = addr_free;
      else               in_ready = 1'b1;
      accept = in_valid && in_ready;
      for (int k = 0; k < WIDTH_OP; k++) begin
         load[k] = accept && (bcast || (in == WIDTH_IN'(k)));
      end
      oob = accept && !bcast && !in_range;
   end

   // Per-lane holding registers: load wins over drain.
   // Load-plus-drain keeps out_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data registers are reset too, not only the valid flags.
         // `out` is visible at the port and must read zero after reset.
         out       <= '0;
         out_valid <= '0;
      end else begin
         for (int k = 0; k < WIDTH_OP; k++) begin
            // NOTE: state is written with non-blocking assignments.
            // Every lane then updates from the same pre-edge values.
            if (load[k]) begin
               out[k]       <= in_data;
               out_valid[k] <= 1'b1;
            end else if (drain[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   // Sticky error flag: set by a swallowed out-of-range word, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      err <= 1'b0;
      else if (oob) err <= 1'b1;
   end

endmodule

// File: doc/demux_arr_module.md
# demux_arr_module

Registered, handshaked demultiplexer: the inverse of the packed-array multiplexer. It accepts one `WIDTH_BUS`-bit word per cycle with a lane index and steers it into a one-entry holding register on the addressed output lane. Each lane drains independently through its own valid/ready pair. It sits where a shared bus fans out to `WIDTH_OP` consumers, for example redistributing the words that a mux stage collected.

## Interface
- `WIDTH_IN`, default 2: lane index width.
- `WIDTH_OP`, default 4: number of output lanes. Must satisfy 1 ≤ `WIDTH_OP` ≤ 2^`WIDTH_IN`.
- `WIDTH_BUS`, default 2: data word width.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: input word offered.
- `in_ready` output, 1 bit: input word accepted this cycle when `in_valid` is also high.
- `in` input, `WIDTH_IN` bits: destination lane index.
- `in_data` input, `WIDTH_BUS` bits: word to route.
- `out` output, [`WIDTH_OP`-1:0][`WIDTH_BUS`-1:0] packed: per-lane held word.
- `out_valid` output, `WIDTH_OP` bits: per-lane word present.
- `out_ready` input, `WIDTH_OP` bits: per-lane consumer takes the word.
- `err` output, 1 bit: sticky flag for an out-of-range index.

## Operation
- Per lane k:
  - Holding register `out[k]` and flag `out_valid[k]`.
  - Drain event: `out_valid[k] && out_ready[k]`.
  - Load event: accepted input with `in == k`.
- Input acceptance:
  - `in_ready` is combinational.
  - If `in < WIDTH_OP`: `in_ready = !out_valid[in] || out_ready[in]`.
  - If `in >= WIDTH_OP`: `in_ready = 1`. The word is discarded and `err` is set to 1. `err` clears only on reset.
- Lane update rules:
  - Load without drain: `out[k] <= in_data`, `out_valid[k] <= 1`.
  - Drain without load: `out_valid[k] <= 0`. `out[k]` holds its last value and is not cleared.
  - Load and drain in the same cycle: `out[k] <= in_data`, `out_valid[k]` stays 1. This gives full throughput of one word per cycle per lane.
  - Neither event: hold.
- Lanes are independent. Any number of lanes may drain in the same cycle. At most one lane loads per cycle.
- While `out_valid[k] = 1`, `out[k]` is stable until it drains.
- `out_ready[k]` while `out_valid[k] = 0` has no effect.
- `in_ready` depends on `out_ready`, but `out_ready` must not depend on `in_ready`. This prevents a combinational loop.

## Timing
- Reset values: `out` = all 0, `out_valid` = 0, `err` = 0.
- Reset is asynchronous; asserting it mid-transfer discards every held word immediately.
- After `rst` is released, the first acceptance can occur on the first rising edge.
- Latency: a word accepted at edge N appears on `out[in]` with `out_valid` high after edge N, one cycle later.
- Backpressure:
  - When the addressed lane is full and not draining, `in_ready = 0`. The source must hold `in`, `in_data` and `in_valid` stable until acceptance.
  - A stall on one lane does not block traffic to other lanes once the source changes `in`. No reordering exists inside the block.
- `err` rises one cycle after the out-of-range acceptance edge.
- With `WIDTH_OP = 2^WIDTH_IN`, `err` is constant 0.

## Configuration
- Macro: `DEMUX_ARR_BROADCAST_EN`.
- When defined:
  - Adds an input port `in_bcast` (1 bit).
  - An accepted word with `in_bcast = 1` loads every lane simultaneously, and `in` is ignored.
  - In broadcast mode, `in_ready = AND over k of (!out_valid[k] || out_ready[k])`. Broadcast is all-or-nothing, never partial.
  - A broadcast never sets `err`.
- When undefined: the `in_bcast` port is absent and behaviour is unicast only, as described above.

## Test plan
All scenarios use `WIDTH_IN=2`, `WIDTH_OP=4`, `WIDTH_BUS=2` unless stated.

1. Reset, then write (in, data) = (0,2'b00), (1,2'b11), (2,2'b10), (3,2'b01) on consecutive cycles with all `out_ready = 0` → `out = {01,10,11,00}` and `out_valid = 4'b1111`. `in_ready` stays 1 throughout.
2. Lane 2 full, `out_ready[2] = 0`, offer (2,2'b01) → `in_ready = 0` and `out[2]` stays 10. Then raise `out_ready[2]` → accepted the same cycle; the next cycle `out[2] = 01` and `out_valid[2] = 1`.
3. Streaming to lane 1 with `out_ready[1] = 1` and data 0,1,2,3 on 4 consecutive cycles → `in_ready` is constantly 1 and each word is visible exactly one cycle.
4. Build with `WIDTH_OP = 3`, offer `in = 3`, data 2'b11 → `in_ready = 1`, no lane changes, and `err = 1` from the next cycle until `rst`.
5. Assert `rst` asynchronously mid-cycle with lanes 0 and 3 full → `out_valid = 0`, `out = 0` and `err = 0` immediately, without waiting for a clock edge.
6. With `DEMUX_ARR_BROADCAST_EN` defined, lane 1 full and not ready, offer broadcast data 2'b10 → `in_ready = 0`. Then set `out_ready[1] = 1` → all 4 lanes hold 10 with `out_valid = 4'b1111`.
